morse_key_decoder: RTL and testbench
====================================

// Module: morse_key_decoder
// PURPOSE
// Decodes a hand-keyed Morse input into 8-bit uppercase ASCII characters for the UART transmit path.
// - Times marks and spaces against a programmable dit unit, classifies each mark as dot or dash and
//   looks the completed symbol up in an A-Z/0-9 table.
// - Presents each decoded character on a valid/ready interface that feeds the UART transmitter.
// PARAMETERS
// UNIT_TICKS  6_000_000  clock cycles per Morse unit (60 ms at 100 MHz = 20 WPM); sim uses 4
// WORD_BITS   8          width of data_o
// MAX_SYMS    6          max dots/dashes per character; 6 bits of pattern storage
// PORTS
// clk_i      in   1          system clock
// reset_i    in   1          synchronous, active-low reset
// key_i      in   1          raw Morse key, 1 = key down (mark); asynchronous
// ready_i    in   1          downstream (UART tx) accepts data_o when high with valid_o
// data_o     out  WORD_BITS  decoded ASCII character
// valid_o    out  1          data_o holds an unconsumed character
// busy_o     out  1          decoder is inside a character (state != IDLE)
// error_o    out  1          1-cycle pulse: completed symbol undecodable or longer than MAX_SYMS
// overrun_o  out  1          sticky: a character was dropped because valid_o was still high
// BEHAVIOUR
// - Reset (reset_i=0 at a clock edge): all outputs 0, state IDLE, synchronizer and counters cleared,
//   partial character discarded. Applies mid-character and mid-handshake alike.
// - key_i passes a 2-FF synchronizer. Rise/fall are detected on the synchronized value, which adds
//   3 cycles of latency.
// - Tick counter counts 0..UNIT_TICKS-1. Each wrap increments a unit counter (4 bits, saturates at 15).
//   Both counters restart on every synchronized edge.
// - IDLE: on rise -> MARK. Clear pattern and sym_cnt; set ovf=0.
// - MARK: on fall, classify the mark. units<2 is a dot (0), including glitches under 1 unit.
//   units>=2 is a dash (1). Shift pattern left and insert the new bit at LSB; sym_cnt++.
//   If sym_cnt was already MAX_SYMS, set ovf and do not shift. Then -> SPACE.
//   A key held indefinitely stays a dash.
// - SPACE: a rise with units<3 -> MARK (same character). When units reaches 3 -> EMIT.
// - EMIT (exactly 1 cycle): look up {sym_cnt, pattern}. 'A' = cnt 2, pattern 01b -> 0x41.
//   '0' = cnt 5, pattern 11111b -> 0x30.
//   - ovf set or no table match: pulse error_o; nothing is loaded.
//   - Match with output register empty, or being accepted this cycle: load data_o, set valid_o.
//   - Match with valid_o=1 and ready_i=0: drop the character, set overrun_o; data_o is unchanged.
//   - Then -> IDLE (or -> WGAP when WORD_GAP_EN).
// - Output handshake:
//   - data_o is stable while valid_o=1.
//   - valid_o&ready_i at a clock edge clears valid_o next cycle, unless a new character loads in
//     that same cycle (valid_o stays 1 with the new data).
//   - ready_i while valid_o=0 is ignored.
// - overrun_o clears only on reset. error_o is never asserted together with a load.
// - Latency: valid_o rises 1 cycle after the space counter reaches 3 units (EMIT cycle registered).
// CONFIGURATION
// WORD_GAP_EN defined:
//   - EMIT goes to WGAP. In WGAP, if units reaches 7 (measured from the last fall) -> emit 0x20 under
//     the same load/overrun rules, then -> IDLE.
//   - A rise in WGAP -> MARK with pattern cleared (new character, no space emitted).
// WORD_GAP_EN undefined: no WGAP state; EMIT -> IDLE; a space character is never emitted.
// TESTING (UNIT_TICKS=4, ready_i=1 unless stated)
// 1. 'A': key 1u high, 1u low, 3u high, 4u low -> one valid_o cycle with data_o=0x41; error_o stays 0.
// 2. 'S' then 'O' with a 3u gap between them -> 0x53 then 0x4F; digit '5' (5 dots) -> 0x35.
// 3. Seven 1u dots with 1u spacing, then 3u low -> error_o pulses once; valid_o stays 0.
// 4. ready_i=0; key 'E' then 'T' -> data_o holds 0x45, overrun_o=1. Raise ready_i -> valid_o
//    drops next cycle.
// 5. Reset (reset_i=0) after two dots of 'S', release, key 'E' -> only 0x45 emitted; outputs 0
//    during reset.
// 6. 'E' then 8u low: with WORD_GAP_EN -> 0x45 then 0x20; without it -> 0x45 only.

Source files
------------

// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - hand-keyed Morse to uppercase ASCII decoder
//
// Purpose:
//   Times marks and spaces of a raw Morse key against a programmable dit
//   unit, classifies each mark as dot or dash, and looks the completed
//   symbol up in an A-Z / 0-9 table. Each decoded character is presented on
//   a valid/ready interface feeding the UART transmitter.
//
// Optional feature (macro WORD_GAP_EN):
//   When defined, a silence of 7 units after the last mark emits 0x20.
//   When undefined there is no word-gap state and a space is never emitted.
//
// Ports:
//   clk_i      in   1          system clock
//   reset_i    in   1          synchronous, active-low reset
//   key_i      in   1          raw key, 1 = key down (mark); asynchronous
//   ready_i    in   1          downstream accepts data_o when high with valid_o
//   data_o     out  WORD_BITS  decoded ASCII character
//   valid_o    out  1          data_o holds an unconsumed character
//   busy_o     out  1          decoder is inside a character
//   error_o    out  1          1-cycle pulse: symbol undecodable or too long
//   overrun_o  out  1          sticky: character dropped while valid_o was high

module morse_key_decoder #(
  parameter int UNIT_TICKS = 6_000_000,
  parameter int WORD_BITS  = 8,
  parameter int MAX_SYMS   = 6
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 key_i,
  input  logic                 ready_i,
  output logic [WORD_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 error_o,
  output logic                 overrun_o
);

  localparam int              TICK_W    = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);
  localparam logic [2:0]      SYM_MAX   = 3'(MAX_SYMS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MARK  = 3'd1;
  localparam logic [2:0] SPACE = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
`ifdef WORD_GAP_EN
  localparam logic [2:0] WGAP  = 3'd4;
`endif

  // Key synchronizer plus one history stage for edge detection.
  logic key_meta;
  logic key_sync;
  logic key_prev;
  logic key_rise;
  logic key_fall;
  logic key_edge;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_meta <= key_i;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign key_rise = key_sync & ~key_prev;
  assign key_fall = ~key_sync & key_prev;
  assign key_edge = key_rise | key_fall;

  // Unit timing. The edge cycle itself is tick 0 of the new interval, so a
  // mark or space of N whole units reads exactly N on the closing edge.
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        unit_cnt;
  logic [TICK_W-1:0] tick_base;
  logic [3:0]        unit_base;

  assign tick_base = key_edge ? '0 : tick_cnt;
  assign unit_base = key_edge ? 4'd0 : unit_cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      tick_cnt <= '0;
      unit_cnt <= 4'd0;
    end else if (tick_base == TICK_LAST) begin
      tick_cnt <= '0;
      unit_cnt <= (unit_base == 4'd15) ? unit_base : unit_base + 4'd1;
    end else begin
      tick_cnt <= tick_base + TICK_W'(1);
      unit_cnt <= unit_base;
    end
  end

  // Symbol table keyed on {count, pattern}; first element sits in the
  // highest used pattern bit, dot = 0, dash = 1. Bit 8 of the result = hit.
  function automatic logic [8:0] morse_lookup(input logic [2:0] cnt,
                                              input logic [5:0] pat);
    logic [8:0] res;
    res = 9'h000;
    case ({cnt, pat})
      9'b001_000000: res = {1'b1, 8'h45}; // E
      9'b001_000001: res = {1'b1, 8'h54}; // T
      9'b010_000000: res = {1'b1, 8'h49}; // I
      9'b010_000001: res = {1'b1, 8'h41}; // A
      9'b010_000010: res = {1'b1, 8'h4E}; // N
      9'b010_000011: res = {1'b1, 8'h4D}; // M
      9'b011_000000: res = {1'b1, 8'h53}; // S
      9'b011_000001: res = {1'b1, 8'h55}; // U
      9'b011_000010: res = {1'b1, 8'h52}; // R
      9'b011_000011: res = {1'b1, 8'h57}; // W
      9'b011_000100: res = {1'b1, 8'h44}; // D
      9'b011_000101: res = {1'b1, 8'h4B}; // K
      9'b011_000110: res = {1'b1, 8'h47}; // G
      9'b011_000111: res = {1'b1, 8'h4F}; // O
      9'b100_000000: res = {1'b1, 8'h48}; // H
      9'b100_000001: res = {1'b1, 8'h56}; // V
      9'b100_000010: res = {1'b1, 8'h46}; // F
      9'b100_000100: res = {1'b1, 8'h4C}; // L
      9'b100_000110: res = {1'b1, 8'h50}; // P
      9'b100_000111: res = {1'b1, 8'h4A}; // J
      9'b100_001000: res = {1'b1, 8'h42}; // B
      9'b100_001001: res = {1'b1, 8'h58}; // X
      9'b100_001010: res = {1'b1, 8'h43}; // C
      9'b100_001011: res = {1'b1, 8'h59}; // Y
      9'b100_001100: res = {1'b1, 8'h5A}; // Z
      9'b100_001101: res = {1'b1, 8'h51}; // Q
      9'b101_000000: res = {1'b1, 8'h35}; // 5
      9'b101_000001: res = {1'b1, 8'h34}; // 4
      9'b101_000011: res = {1'b1, 8'h33}; // 3
      9'b101_000111: res = {1'b1, 8'h32}; // 2
      9'b101_001111: res = {1'b1, 8'h31}; // 1
      9'b101_010000: res = {1'b1, 8'h36}; // 6
      9'b101_011000: res = {1'b1, 8'h37}; // 7
      9'b101_011100: res = {1'b1, 8'h38}; // 8
      9'b101_011110: res = {1'b1, 8'h39}; // 9
      9'b101_011111: res = {1'b1, 8'h30}; // 0
      default:       res = 9'h000;
    endcase
    return res;
  endfunction

  logic [2:0]          state;
  logic [MAX_SYMS-1:0] pattern;
  logic [2:0]          sym_cnt;
  logic                ovf;
  logic [8:0]          lookup;
  logic                load_req;
  logic [7:0]          load_char;
  logic                err_req;

  assign lookup = morse_lookup(sym_cnt, pattern);
  assign busy_o = (state != IDLE);

  // Character delivery requests for this cycle; at most one of load/err.
  always_comb begin
    load_req  = 1'b0;
    load_char = 8'h00;
    err_req   = 1'b0;
    if (state == EMIT) begin
      if (lookup[8] && !ovf) begin
        load_req  = 1'b1;
        load_char = lookup[7:0];
      end else begin
        err_req = 1'b1;
      end
    end
`ifdef WORD_GAP_EN
    if (state == WGAP && unit_cnt >= 4'd7) begin
      load_req  = 1'b1;
      load_char = 8'h20;
    end
`endif
  end

  // Sequencer. A rise that lands on the same cycle the space expires is
  // not lost: EMIT (and the word-gap exit) see the key already down and
  // start the next character directly, timing from that rise.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      pattern <= '0;
      sym_cnt <= 3'd0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_rise) begin
            state   <= MARK;
            pattern <= '0;
            sym_cnt <= 3'd0;
            ovf     <= 1'b0;
          end
        end
        MARK: begin
          if (key_fall) begin
            if (sym_cnt == SYM_MAX) begin
              ovf <= 1'b1;
            end else begin
              pattern <= {pattern[MAX_SYMS-2:0], (unit_cnt >= 4'd2)};
              sym_cnt <= sym_cnt + 3'd1;
            end
            state <= SPACE;
          end
        end
        SPACE: begin
          if (unit_cnt >= 4'd3) begin
            state <= EMIT;
          end else if (key_rise) begin
            state <= MARK;
          end
        end
        EMIT: begin
          if (key_sync) begin
            state   <= MARK;
            pattern <= '0;
            sym_cnt <= 3'd0;
            ovf     <= 1'b0;
          end else begin
`ifdef WORD_GAP_EN
            state <= WGAP;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef WORD_GAP_EN
        WGAP: begin
          if (unit_cnt >= 4'd7) begin
            if (key_sync) begin
              state   <= MARK;
              pattern <= '0;
              sym_cnt <= 3'd0;
              ovf     <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (key_rise) begin
            state   <= MARK;
            pattern <= '0;
            sym_cnt <= 3'd0;
            ovf     <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Output register and handshake. A new load wins over the acceptance
  // clear, so back-to-back characters keep valid_o high.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      error_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      error_o <= err_req;
      if (load_req) begin
        if (!valid_o || ready_i) begin
          data_o  <= WORD_BITS'(load_char);
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb/tb_morse_key_decoder.sv - scoreboard bench for morse_key_decoder

module tb_morse_key_decoder;

  localparam int U = 4;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       key_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       error_o;
  logic       overrun_o;

  always #5 clk_i = ~clk_i;

  morse_key_decoder #(.UNIT_TICKS(U), .WORD_BITS(8), .MAX_SYMS(6)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .key_i    (key_i),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .error_o  (error_o),
    .overrun_o(overrun_o)
  );

  int         checks   = 0;
  int         failures = 0;
  int         err_seen = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted character, counts error
  // pulses and checks data stability while the output is held.
  logic [7:0] prev_data = 8'h00;
  logic       prev_hold = 1'b0;

  always @(negedge clk_i) begin
    if (reset_i) begin
      if (prev_hold && valid_o) begin
        checks++;
        if (data_o !== prev_data) begin
          failures++;
          $display("FAIL hold_stable: got 0x%0h expected 0x%0h", data_o, prev_data);
        end
      end
      if (error_o) err_seen++;
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_char: got 0x%0h expected none", data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin
            failures++;
            $display("FAIL char: got 0x%0h expected 0x%0h", data_o, e);
          end
        end
      end
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic key_sym(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      key_i = 1'b1;
      cyc((s[i] == 8'h2d) ? 3 * U : U);
      key_i = 1'b0;
      cyc((i == s.len() - 1) ? gap * U : U);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cyc(1);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic end_word();
`ifdef WORD_GAP_EN
    exp_q.push_back(8'h20);
`endif
    cyc(10 * U);
    drain();
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b0;
    key_i   = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_data", data_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_error", error_o, 0);
    chk("reset_overrun", overrun_o, 0);
    cyc(1);
    reset_i = 1'b1;
    cyc(2 * U);

    // 'A'
    exp_q.push_back(8'h41);
    key_sym(".-", 4);
    end_word();
    chk("a_errors", err_seen, exp_err);

    // 'S', 3-unit gap, 'O', then '5'
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h35);
    key_sym("...", 3);
    key_sym("---", 4);
    key_sym(".....", 4);
    end_word();
    chk("so5_errors", err_seen, exp_err);

    // Seven dots overflow, then an undecodable 4-symbol pattern
    exp_err++;
    key_sym(".......", 4);
    cyc(2);
    chk("ovf_valid", valid_o, 0);
    exp_err++;
    key_sym("..--", 4);
    end_word();
    chk("bad_errors", err_seen, exp_err);

    // Backpressure: 'E' held, 'T' dropped
    ready_i = 1'b0;
    exp_q.push_back(8'h45);
    key_sym(".", 4);
    key_sym("-", 4);
    cyc(6 * U);
    chk("bp_valid", valid_o, 1);
    chk("bp_data", data_o, 8'h45);
    chk("bp_overrun", overrun_o, 1);
    ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("bp_valid_drop", valid_o, 0);
    cyc(10 * U);
    drain();

    // Reset mid-character after two dots of 'S'
    key_i = 1'b1; cyc(U);
    key_i = 1'b0; cyc(U);
    key_i = 1'b1; cyc(U);
    key_i = 1'b0; cyc(2);
    reset_i = 1'b0;
    cyc(2);
    @(negedge clk_i);
    chk("mid_reset_data", data_o, 0);
    chk("mid_reset_valid", valid_o, 0);
    chk("mid_reset_busy", busy_o, 0);
    chk("mid_reset_error", error_o, 0);
    chk("mid_reset_overrun", overrun_o, 0);
    cyc(1);
    reset_i = 1'b1;
    cyc(4 * U);
    chk("post_reset_busy", busy_o, 0);
    exp_q.push_back(8'h45);
    key_sym(".", 4);
    end_word();

    // 'E' then 8 units of silence
    exp_q.push_back(8'h45);
`ifdef WORD_GAP_EN
    exp_q.push_back(8'h20);
`endif
    key_sym(".", 8);
    cyc(4 * U);
    drain();
    chk("final_errors", err_seen, exp_err);
    chk("final_valid", valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
